// File: rtl/dpr_pkg.sv
// Shared definitions for FIFOs and buffers that sit in front of the True_DPR dual-port RAM.
// Pointers carry one extra wrap bit above the RAM address so full and empty can be told apart.
package dpr_pkg;

  localparam int DEF_ADDR_SIZE = 8;
  localparam int DEF_DATA_SIZE = 8;
  localparam int DEPTH         = 1 << DEF_ADDR_SIZE;
  localparam int PTR_W         = DEF_ADDR_SIZE + 1;

  // Widest pointer the helper handles; narrower pointers are zero-extended into it.
  localparam int MAX_ADDR_SIZE = 16;
  localparam int MAX_PTR_W     = MAX_ADDR_SIZE + 1;

  typedef struct packed {
    logic full;
    logic empty;
  } ptr_flags_t;

  // Equal pointers mean empty; equal address bits with differing wrap bits mean full.
  function automatic ptr_flags_t ptr_flags(input logic [MAX_PTR_W-1:0] wr,
                                           input logic [MAX_PTR_W-1:0] rd,
                                           input int unsigned          addr_size);
    logic [MAX_PTR_W-1:0] diff;
    logic [MAX_PTR_W-1:0] low_mask;
    logic [MAX_PTR_W-1:0] wrap_mask;
    ptr_flags_t           f;
    diff      = wr ^ rd;
    wrap_mask = MAX_PTR_W'(1) << addr_size;
    low_mask  = wrap_mask - MAX_PTR_W'(1);
    f.empty   = (diff == '0);
    f.full    = ((diff & wrap_mask) != '0) && ((diff & low_mask) == '0);
    return f;
  endfunction

endpackage

// File: rtl/dpr_fifo_ctrl_if.sv
// FIFO user-side bundle for dpr_fifo_ctrl: push/pop requests, pop data and status.
interface dpr_fifo_ctrl_if #(
  parameter int ADDR_SIZE = 8,
  parameter int DATA_SIZE = 8
);

  // push/pop are single-cycle requests; push is taken only when !full and pop only when
  // !empty (flags as seen at the start of the cycle). A taken pop returns its word on
  // pop_data with pop_valid=1 exactly one cycle later; there is no backpressure on pop_data.
  logic                 push;
  logic [DATA_SIZE-1:0] push_data;
  logic                 pop;
  logic [DATA_SIZE-1:0] pop_data;
  logic                 pop_valid;
  logic                 full;
  logic                 empty;
  logic                 almost_full;
  logic [ADDR_SIZE:0]   count;
  logic                 overflow;
  logic                 underflow;

  modport master (
    output push, push_data, pop,
    input  pop_data, pop_valid, full, empty, almost_full, count, overflow, underflow
  );

  modport slave (
    input  push, push_data, pop,
    output pop_data, pop_valid, full, empty, almost_full, count, overflow, underflow
  );

endinterface

// File: rtl/dpr_fifo_ctrl.sv
// FIFO controller driving a True_DPR: port A writes at wr_ptr, port B reads at rd_ptr,
// pop data arrives straight from the RAM one cycle after the accepted pop.
module dpr_fifo_ctrl
  import dpr_pkg::*;
#(
  parameter int ADDR_SIZE = DEF_ADDR_SIZE,
  parameter int DATA_SIZE = DEF_DATA_SIZE,
  parameter int AF_LEVEL  = (1 << ADDR_SIZE) - 2
) (
  input  logic                 clk,
  input  logic                 rst,
  dpr_fifo_ctrl_if.slave       fifo,
  output logic                 ram_en_a,
  output logic                 ram_we_a,
  output logic [ADDR_SIZE-1:0] ram_addr_a,
  output logic [DATA_SIZE-1:0] ram_din_a,
  output logic                 ram_en_b,
  output logic                 ram_we_b,
  output logic [ADDR_SIZE-1:0] ram_addr_b,
  input  logic [DATA_SIZE-1:0] ram_dout_b
);

  localparam int P_W = ADDR_SIZE + 1;

  logic [P_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [P_W-1:0] rd_ptr_q, rd_ptr_d;
  logic           pop_valid_q, pop_valid_d;
  logic           overflow_q, overflow_d;
  logic           underflow_q, underflow_d;

  ptr_flags_t     flags;
  logic           full;
  logic           empty;
  logic [P_W-1:0] count;
  logic           push_acc;
  logic           pop_acc;

  // Flags come from the registered pointers, so they describe the start of the cycle.
  always_comb begin
    flags    = ptr_flags(MAX_PTR_W'(wr_ptr_q), MAX_PTR_W'(rd_ptr_q), ADDR_SIZE);
    full     = flags.full;
    empty    = flags.empty;
    count    = wr_ptr_q - rd_ptr_q;
    push_acc = fifo.push & ~full & ~rst;
    pop_acc  = fifo.pop & ~empty & ~rst;
  end

  // Requests seen during rst are dropped and do not raise the sticky error flags.
  always_comb begin
    wr_ptr_d    = wr_ptr_q + P_W'(push_acc);
    rd_ptr_d    = rd_ptr_q + P_W'(pop_acc);
    pop_valid_d = pop_acc;
    overflow_d  = overflow_q | (fifo.push & full);
    underflow_d = underflow_q | (fifo.pop & empty);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      pop_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      pop_valid_q <= pop_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign ram_en_a   = push_acc;
  assign ram_we_a   = push_acc;
  assign ram_addr_a = wr_ptr_q[ADDR_SIZE-1:0];
  assign ram_din_a  = fifo.push_data;
  assign ram_en_b   = pop_acc;
  assign ram_we_b   = 1'b0;
  assign ram_addr_b = rd_ptr_q[ADDR_SIZE-1:0];

  assign fifo.pop_data    = ram_dout_b;
  assign fifo.pop_valid   = pop_valid_q;
  assign fifo.full        = full;
  assign fifo.empty       = empty;
  assign fifo.count       = count;
  assign fifo.almost_full = (int'(count) >= AF_LEVEL);
  assign fifo.overflow    = overflow_q;
  assign fifo.underflow   = underflow_q;

endmodule

// File: tb/tb_dpr_fifo_ctrl.sv
// Directed bench for dpr_fifo_ctrl at ADDR_SIZE=2 with a small one-cycle-latency RAM model.
module tb_dpr_fifo_ctrl;

  localparam int AW = 2;
  localparam int DW = 8;

  logic          clk;
  logic          rst;
  logic          ram_en_a, ram_we_a, ram_en_b, ram_we_b;
  logic [AW-1:0] ram_addr_a, ram_addr_b;
  logic [DW-1:0] ram_din_a, ram_dout_b;
  logic [DW-1:0] mem [1 << AW];

  int errors = 0;
  int checks = 0;

  dpr_fifo_ctrl_if #(.ADDR_SIZE(AW), .DATA_SIZE(DW)) fifo_if ();

  dpr_fifo_ctrl #(.ADDR_SIZE(AW), .DATA_SIZE(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo       (fifo_if),
    .ram_en_a   (ram_en_a),
    .ram_we_a   (ram_we_a),
    .ram_addr_a (ram_addr_a),
    .ram_din_a  (ram_din_a),
    .ram_en_b   (ram_en_b),
    .ram_we_b   (ram_we_b),
    .ram_addr_b (ram_addr_b),
    .ram_dout_b (ram_dout_b)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RAM model: registered read on port B, write on port A
  always @(posedge clk) begin
    if (ram_en_a && ram_we_a) mem[ram_addr_a] <= ram_din_a;
    if (ram_en_b) ram_dout_b <= mem[ram_addr_b];
  end

  // both ports enabled must never address the same word
  always @(negedge clk) begin
    #2;
    if (ram_en_a === 1'b1 && ram_en_b === 1'b1) begin
      checks++;
      if (ram_addr_a === ram_addr_b) begin
        errors++;
        $display("FAIL addr_collision: addr_a=%0h addr_b=%0h required different", ram_addr_a, ram_addr_b);
      end
    end
  end

  // driver: apply one cycle of inputs at the falling edge, settle, then return for checks
  task automatic cyc(input logic r, input logic p, input logic [DW-1:0] d, input logic q);
    @(negedge clk);
    rst               = r;
    fifo_if.push      = p;
    fifo_if.push_data = d;
    fifo_if.pop       = q;
    #1;
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, 1'b1, 8'h5A, 1'b1);
      checks++; if ({ram_en_a, ram_we_a, ram_en_b, ram_we_b} !== 4'b0000) begin errors++;
        $display("FAIL reset_strobes: got %b required 0000", {ram_en_a, ram_we_a, ram_en_b, ram_we_b}); end
    end
    checks++; if (fifo_if.empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b required 1", fifo_if.empty); end
    checks++; if (fifo_if.count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d required 0", fifo_if.count); end
    checks++; if ({fifo_if.overflow, fifo_if.underflow} !== 2'b00) begin errors++;
      $display("FAIL reset_errflags: got %b required 00", {fifo_if.overflow, fifo_if.underflow}); end
    checks++; if (fifo_if.full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b required 0", fifo_if.full); end
  endtask

  task automatic test_single_word();
    do_reset();
    cyc(1'b0, 1'b1, 8'hA1, 1'b0);
    checks++; if ({ram_en_a, ram_we_a, ram_addr_a, ram_din_a} !== {2'b11, 2'd0, 8'hA1}) begin errors++;
      $display("FAIL single_write: en/we/addr/din=%b%b/%0h/%0h required 11/0/a1", ram_en_a, ram_we_a, ram_addr_a, ram_din_a); end
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    checks++; if ({ram_en_b, ram_addr_b} !== {1'b1, 2'd0}) begin errors++;
      $display("FAIL single_read: en_b=%b addr_b=%0h required 1/0", ram_en_b, ram_addr_b); end
    checks++; if (fifo_if.count !== 3'd1) begin errors++; $display("FAIL single_count: got %0d required 1", fifo_if.count); end
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    checks++; if ({fifo_if.pop_valid, fifo_if.pop_data} !== {1'b1, 8'hA1}) begin errors++;
      $display("FAIL single_data: valid=%b data=%0h required 1/a1", fifo_if.pop_valid, fifo_if.pop_data); end
    checks++; if (fifo_if.empty !== 1'b1) begin errors++; $display("FAIL single_empty: got %b required 1", fifo_if.empty); end
  endtask

  task automatic test_fill_overflow();
    logic [2:0] exp_cnt [4] = '{3'd0, 3'd1, 3'd2, 3'd3};
    logic       exp_af  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b1, 8'(8'h10 + i), 1'b0);
      checks++; if (fifo_if.count !== exp_cnt[i] || fifo_if.almost_full !== exp_af[i]) begin errors++;
        $display("FAIL fill_level[%0d]: count=%0d af=%b required %0d/%b", i, fifo_if.count, fifo_if.almost_full, exp_cnt[i], exp_af[i]); end
      checks++; if ({ram_we_a, ram_addr_a} !== {1'b1, 2'(i)}) begin errors++;
        $display("FAIL fill_write[%0d]: we=%b addr=%0h required 1/%0h", i, ram_we_a, ram_addr_a, i); end
    end
    cyc(1'b0, 1'b1, 8'h14, 1'b0);
    checks++; if ({fifo_if.full, fifo_if.count, fifo_if.almost_full} !== {1'b1, 3'd4, 1'b1}) begin errors++;
      $display("FAIL fill_full: full=%b count=%0d af=%b required 1/4/1", fifo_if.full, fifo_if.count, fifo_if.almost_full); end
    checks++; if ({ram_en_a, ram_we_a} !== 2'b00) begin errors++;
      $display("FAIL overflow_reject: en/we=%b%b required 00", ram_en_a, ram_we_a); end
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b0, 8'h00, i < 4);
      if (i == 0) begin
        checks++; if (fifo_if.overflow !== 1'b1) begin errors++; $display("FAIL overflow_flag: got %b required 1", fifo_if.overflow); end
      end else begin
        checks++; if ({fifo_if.pop_valid, fifo_if.pop_data} !== {1'b1, 8'(8'h10 + i - 1)}) begin errors++;
          $display("FAIL drain_data[%0d]: valid=%b data=%0h required 1/%0h", i - 1, fifo_if.pop_valid, fifo_if.pop_data, 8'h10 + i - 1); end
      end
    end
    checks++; if ({fifo_if.empty, fifo_if.count, fifo_if.overflow} !== {1'b1, 3'd0, 1'b1}) begin errors++;
      $display("FAIL drain_end: empty=%b count=%0d ovf=%b required 1/0/1", fifo_if.empty, fifo_if.count, fifo_if.overflow); end
  endtask

  task automatic test_wraparound();
    logic p, q;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      p = (i < 10);
      q = (i >= 1 && i <= 10);
      cyc(1'b0, p, 8'(i), q);
      if (p) begin
        checks++; if ({ram_we_a, ram_addr_a, ram_din_a} !== {1'b1, 2'(i % 4), 8'(i)}) begin errors++;
          $display("FAIL wrap_write[%0d]: we=%b addr=%0h din=%0h required 1/%0h/%0h", i, ram_we_a, ram_addr_a, ram_din_a, i % 4, i); end
      end
      if (q) begin
        checks++; if ({ram_en_b, ram_addr_b} !== {1'b1, 2'((i - 1) % 4)}) begin errors++;
          $display("FAIL wrap_read[%0d]: en_b=%b addr_b=%0h required 1/%0h", i, ram_en_b, ram_addr_b, (i - 1) % 4); end
      end
      checks++; if (fifo_if.count !== (q ? 3'd1 : 3'd0)) begin errors++;
        $display("FAIL wrap_count[%0d]: got %0d required %0d", i, fifo_if.count, q ? 1 : 0); end
      if (i >= 2) begin
        checks++; if ({fifo_if.pop_valid, fifo_if.pop_data} !== {1'b1, 8'(i - 2)}) begin errors++;
          $display("FAIL wrap_data[%0d]: valid=%b data=%0h required 1/%0h", i, fifo_if.pop_valid, fifo_if.pop_data, i - 2); end
      end
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 8'(8'h40 + i), 1'b0);
    cyc(1'b0, 1'b1, 8'h55, 1'b1);
    checks++; if ({fifo_if.count, ram_en_a, ram_en_b, ram_addr_b} !== {3'd4, 1'b0, 1'b1, 2'd0}) begin errors++;
      $display("FAIL sim_full_strobes: count=%0d en_a=%b en_b=%b addr_b=%0h required 4/0/1/0", fifo_if.count, ram_en_a, ram_en_b, ram_addr_b); end
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    checks++; if ({fifo_if.count, fifo_if.full, fifo_if.overflow} !== {3'd3, 1'b0, 1'b1}) begin errors++;
      $display("FAIL sim_full_after: count=%0d full=%b ovf=%b required 3/0/1", fifo_if.count, fifo_if.full, fifo_if.overflow); end
    checks++; if ({fifo_if.pop_valid, fifo_if.pop_data} !== {1'b1, 8'h40}) begin errors++;
      $display("FAIL sim_full_data: valid=%b data=%0h required 1/40", fifo_if.pop_valid, fifo_if.pop_data); end

    do_reset();
    cyc(1'b0, 1'b1, 8'h66, 1'b1);
    checks++; if ({ram_en_a, ram_addr_a, ram_en_b} !== {1'b1, 2'd0, 1'b0}) begin errors++;
      $display("FAIL sim_empty_strobes: en_a=%b addr_a=%0h en_b=%b required 1/0/0", ram_en_a, ram_addr_a, ram_en_b); end
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    checks++; if ({fifo_if.count, fifo_if.underflow, fifo_if.overflow, fifo_if.pop_valid} !== {3'd1, 1'b1, 1'b0, 1'b0}) begin errors++;
      $display("FAIL sim_empty_after: count=%0d udf=%b ovf=%b valid=%b required 1/1/0/0",
               fifo_if.count, fifo_if.underflow, fifo_if.overflow, fifo_if.pop_valid); end

    do_reset();
    cyc(1'b0, 1'b1, 8'h20, 1'b0);
    cyc(1'b0, 1'b1, 8'h21, 1'b0);
    cyc(1'b0, 1'b1, 8'h22, 1'b1);
    checks++; if ({fifo_if.count, ram_en_a, ram_en_b, ram_addr_a, ram_addr_b} !== {3'd2, 1'b1, 1'b1, 2'd2, 2'd0}) begin errors++;
      $display("FAIL sim_mid_strobes: count=%0d en_a=%b en_b=%b addr_a=%0h addr_b=%0h required 2/1/1/2/0",
               fifo_if.count, ram_en_a, ram_en_b, ram_addr_a, ram_addr_b); end
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    checks++; if ({fifo_if.count, fifo_if.pop_valid, fifo_if.pop_data} !== {3'd2, 1'b1, 8'h20}) begin errors++;
      $display("FAIL sim_mid_after: count=%0d valid=%b data=%0h required 2/1/20", fifo_if.count, fifo_if.pop_valid, fifo_if.pop_data); end
  endtask

  task automatic test_reset_mid_stream();
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 8'(8'h30 + i), 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    cyc(1'b1, 1'b1, 8'h99, 1'b1);
    checks++; if (fifo_if.count !== 3'd3) begin errors++; $display("FAIL rst_mid_count: got %0d required 3", fifo_if.count); end
    checks++; if ({ram_en_a, ram_we_a, ram_en_b} !== 3'b000) begin errors++;
      $display("FAIL rst_mid_strobes: got %b required 000", {ram_en_a, ram_we_a, ram_en_b}); end
    checks++; if ({fifo_if.pop_valid, fifo_if.pop_data} !== {1'b1, 8'h30}) begin errors++;
      $display("FAIL rst_mid_data: valid=%b data=%0h required 1/30", fifo_if.pop_valid, fifo_if.pop_data); end
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    checks++; if ({fifo_if.count, fifo_if.empty, fifo_if.pop_valid, fifo_if.overflow, fifo_if.underflow} !== {3'd0, 4'b1000}) begin errors++;
      $display("FAIL rst_mid_after: count=%0d empty=%b valid=%b ovf=%b udf=%b required 0/1/0/0/0",
               fifo_if.count, fifo_if.empty, fifo_if.pop_valid, fifo_if.overflow, fifo_if.underflow); end
    cyc(1'b0, 1'b1, 8'h77, 1'b0);
    checks++; if ({ram_we_a, ram_addr_a, ram_din_a} !== {1'b1, 2'd0, 8'h77}) begin errors++;
      $display("FAIL rst_mid_rewrite: we=%b addr=%0h din=%0h required 1/0/77", ram_we_a, ram_addr_a, ram_din_a); end
  endtask

  initial begin
    rst               = 1'b1;
    fifo_if.push      = 1'b1;
    fifo_if.push_data = 8'h00;
    fifo_if.pop       = 1'b1;
    test_reset();
    test_single_word();
    test_fill_overflow();
    test_wraparound();
    test_simultaneous();
    test_reset_mid_stream();
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dpr_fifo_ctrl.md
Name: dpr_fifo_ctrl

Overview:
- Synchronous FIFO controller that sits directly upstream of the True_DPR dual-port RAM and drives its ports.
- Port A is used as the write port and port B as the read port.
- Turns push/pop requests into RAM enable, write-enable and address strobes, and consumes dout_b as pop data.
- Tracks occupancy, full/empty, almost-full and sticky overflow/underflow errors.

Parameters:
ADDR_SIZE, 8, RAM address width; FIFO depth = 1 << ADDR_SIZE
DATA_SIZE, 8, data width; must match the attached True_DPR
AF_LEVEL, (1 << ADDR_SIZE) - 2, almost_full asserts when count >= AF_LEVEL

Ports:
clk  in  1  single clock; all state changes on the rising edge
rst  in  1  synchronous, active-high reset
push  in  1  write request
push_data  in  DATA_SIZE  data to enqueue
pop  in  1  read request
pop_data  out  DATA_SIZE  dequeued word; passthrough of ram_dout_b; meaningful only while pop_valid=1
pop_valid  out  1  pop_data holds the word from the pop accepted in the previous cycle
full  out  1  FIFO holds DEPTH words
empty  out  1  FIFO holds 0 words
almost_full  out  1  count >= AF_LEVEL
count  out  ADDR_SIZE+1  current occupancy, 0..DEPTH
overflow  out  1  sticky: a push arrived while full
underflow  out  1  sticky: a pop arrived while empty
ram_en_a, ram_we_a  out  1 each  RAM port A enable and write-enable
ram_addr_a  out  ADDR_SIZE  RAM port A address
ram_din_a  out  DATA_SIZE  RAM port A write data
ram_en_b, ram_we_b  out  1 each  RAM port B enable; ram_we_b tied to 0
ram_addr_b  out  ADDR_SIZE  RAM port B address
ram_dout_b  in  DATA_SIZE  RAM port B read data; one-cycle read latency

Behaviour:
- Pointers: wr_ptr and rd_ptr, each ADDR_SIZE+1 bits. The low ADDR_SIZE bits form the RAM address; the MSB is the wrap bit. Both wrap modulo 2*DEPTH.
- Flags:
  - empty = (wr_ptr == rd_ptr).
  - full = MSBs differ and low bits are equal.
  - count = wr_ptr - rd_ptr, modulo 2^(ADDR_SIZE+1).
- Acceptance: push_acc = push & ~full & ~rst; pop_acc = pop & ~empty & ~rst. Full and empty are the registered values at the start of the cycle.
- RAM drive (combinational):
  - ram_en_a = ram_we_a = push_acc; ram_addr_a = wr_ptr low bits; ram_din_a = push_data.
  - ram_en_b = pop_acc; ram_addr_b = rd_ptr low bits.
- On each edge, wr_ptr increments if push_acc and rd_ptr increments if pop_acc.
- pop_valid is registered as pop_acc, so pop_data is valid exactly one cycle after the accepted pop.
- Simultaneous push and pop:
  - Both accepted: count is unchanged and both pointers advance.
  - When full: the pop is accepted and the push is rejected.
  - When empty: the push is accepted and the pop is rejected. There is no write-to-read bypass; first-word latency is push cycle, then pop cycle, then data one cycle later.
- Address collision cannot occur: with both ports enabled the FIFO is neither empty nor full, so the addresses differ. Verification asserts ram_en_a & ram_en_b implies ram_addr_a != ram_addr_b.
- Errors: overflow sets on push & full; underflow sets on pop & empty. Both hold until rst. A rejected request has no other effect.
- Reset (synchronous, rst=1 at the edge):
  - Pointers = 0, count = 0, empty = 1, full = 0, almost_full = (AF_LEVEL == 0).
  - pop_valid = 0, overflow = 0, underflow = 0.
  - All RAM strobes are held 0 while rst=1.
  - RAM contents are not cleared.
- Reset mid-operation: a pop accepted in the cycle before rst rises still yields pop_valid=1 in the rst cycle. Any request presented during rst is dropped and raises no error flag.

Decomposition:
- Shared package dpr_pkg holds:
  - localparam DEPTH = 1 << ADDR_SIZE;
  - PTR_W = ADDR_SIZE + 1;
  - a function computing full/empty from two pointers, reused by future RAM-based buffers.
- No internal sub-module. A wrapper one level up, dpr_fifo, instantiates dpr_fifo_ctrl plus True_DPR.

Test Plan:
- Reset: hold rst for 2 cycles with push=pop=1. Required: empty=1, count=0, overflow=underflow=0, all ram_en=0.
- Single word: push 0xA1 in cycle 1, pop in cycle 2. Required: ram_addr_a=0x00 with we_a=1 in cycle 1; ram_addr_b=0x00 in cycle 2; pop_valid=1 and pop_data=0xA1 in cycle 3; empty=1 afterwards.
- Fill and overflow (ADDR_SIZE=2):
  - Push 0x10..0x13. Required: almost_full after the 2nd push, full=1 and count=4 after the 4th.
  - Push 0x14. Required: rejected, ram_we_a=0, overflow=1.
  - Pop all four. Required: 0x10..0x13 in order.
- Wrap-around (ADDR_SIZE=2): 10 push/pop pairs with data 0x00..0x09. Required: addresses cycle 0,1,2,3,0..., data order preserved, count never exceeds 1.
- Simultaneous push and pop:
  - When full: pop accepted, push rejected, count drops 4 to 3.
  - When empty: push accepted, pop rejected, underflow=1, count becomes 1.
  - Mid-level with count=2: count stays 2.
- Reset during stream: assert rst while count=3. Required: count=0, empty=1, next push writes address 0x00.
